// File: rtl/vppm_word_deframer.sv
// Word deframer behind the VPPM demodulator: preamble/SFD hunt, MSB-first deserialization,
// valid/ready output register. Optional per-word even parity when VPPM_DEFRAMER_PARITY_EN is defined.
module vppm_word_deframer #(
    parameter int                  WORD_BITS   = 12,
    parameter int                  MIN_ZEROS   = 5,
    parameter int                  SFD_BITS    = 4,
    parameter logic [SFD_BITS-1:0] SFD_PATTERN = 4'b1010,
    parameter int                  FRAME_WORDS = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 freq_lock,
    input  logic                 bit_in,
    input  logic                 bit_stb,
    output logic [WORD_BITS-1:0] out_data,
    output logic                 out_perr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sync_locked,
    output logic                 frame_done,
    output logic                 overflow
);

    localparam int                  BCW      = $clog2(WORD_BITS + 1);
    localparam logic [BCW-1:0]      BC_ONE   = BCW'(1);
    localparam logic [BCW-1:0]      BC_LAST  = BCW'(WORD_BITS - 1);
    localparam logic [3:0]          MZ4      = 4'(MIN_ZEROS);
    localparam logic [4:0]          SFD_LAST = 5'(SFD_BITS - 1);
    localparam logic [15:0]         SFD_P16  = 16'(SFD_PATTERN);
    localparam logic [15:0]         FW16     = 16'(FRAME_WORDS);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_SFD  = 2'd1,
        ST_DATA = 2'd2,
        ST_PAR  = 2'd3
    } state_t;

`ifdef VPPM_DEFRAMER_PARITY_EN
    function automatic logic even_par_err(input logic [WORD_BITS-1:0] w, input logic p);
        return ^{w, p};
    endfunction
`endif

    state_t                 state_q, state_d;
    logic [3:0]             zero_cnt_q, zero_cnt_d;
    logic [4:0]             sfd_idx_q, sfd_idx_d;
    logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [15:0]            word_cnt_q, word_cnt_d;
    logic [WORD_BITS-1:0]   shreg_q, shreg_d;
    logic [WORD_BITS-1:0]   out_data_q, out_data_d;
    logic                   out_perr_q, out_perr_d;
    logic                   out_valid_q, out_valid_d;
    logic                   sync_locked_q, sync_locked_d;
    logic                   frame_done_q, frame_done_d;
    logic                   overflow_q, overflow_d;
    logic                   push_s;
    logic [WORD_BITS-1:0]   push_word_s;
    logic                   push_perr_s;
    logic [15:0]            sfd_tmp_s;

    // Next-state logic: hunt/SFD/data sequencing plus output-register handshake.
    always_comb begin
        state_d       = state_q;
        zero_cnt_d    = zero_cnt_q;
        sfd_idx_d     = sfd_idx_q;
        bit_cnt_d     = bit_cnt_q;
        word_cnt_d    = word_cnt_q;
        shreg_d       = shreg_q;
        out_data_d    = out_data_q;
        out_perr_d    = out_perr_q;
        out_valid_d   = out_valid_q & ~out_ready;
        overflow_d    = overflow_q;
        frame_done_d  = 1'b0;
        push_s        = 1'b0;
        push_word_s   = {WORD_BITS{1'b0}};
        push_perr_s   = 1'b0;
        sfd_tmp_s     = SFD_P16 >> (SFD_LAST - sfd_idx_q);

        if (!freq_lock) begin
            state_d    = ST_HUNT;
            zero_cnt_d = 4'd0;
        end else if (bit_stb) begin
            case (state_q)
                ST_HUNT: begin
                    if (!bit_in) begin
                        if (zero_cnt_q != 4'd15) begin
                            zero_cnt_d = zero_cnt_q + 4'd1;
                        end else begin
                            zero_cnt_d = zero_cnt_q;
                        end
                    end else if (zero_cnt_q >= MZ4) begin
                        if (SFD_BITS == 1) begin
                            state_d    = ST_DATA;
                            bit_cnt_d  = {BCW{1'b0}};
                            word_cnt_d = 16'd0;
                        end else begin
                            state_d   = ST_SFD;
                            sfd_idx_d = 5'd1;
                        end
                    end else begin
                        zero_cnt_d = 4'd0;
                    end
                end
                ST_SFD: begin
                    if (bit_in == sfd_tmp_s[0]) begin
                        if (sfd_idx_q == SFD_LAST) begin
                            state_d    = ST_DATA;
                            bit_cnt_d  = {BCW{1'b0}};
                            word_cnt_d = 16'd0;
                        end else begin
                            sfd_idx_d = sfd_idx_q + 5'd1;
                        end
                    end else begin
                        state_d    = ST_HUNT;
                        zero_cnt_d = bit_in ? 4'd0 : 4'd1;
                    end
                end
                ST_DATA: begin
                    shreg_d   = {shreg_q[WORD_BITS-2:0], bit_in};
                    bit_cnt_d = bit_cnt_q + BC_ONE;
                    if (bit_cnt_q == BC_LAST) begin
`ifdef VPPM_DEFRAMER_PARITY_EN
                        state_d = ST_PAR;
`else
                        push_s      = 1'b1;
                        push_word_s = {shreg_q[WORD_BITS-2:0], bit_in};
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_PAR: begin
`ifdef VPPM_DEFRAMER_PARITY_EN
                    push_s      = 1'b1;
                    push_word_s = shreg_q;
                    push_perr_s = even_par_err(shreg_q, bit_in);
`else
                    state_d = ST_HUNT;
`endif
                end
                default: state_d = ST_HUNT;
            endcase

            // A push that meets a still-unread word drops the new one and latches overflow.
            if (push_s) begin
                if (!out_valid_q || out_ready) begin
                    out_data_d  = push_word_s;
                    out_perr_d  = push_perr_s;
                    out_valid_d = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
                word_cnt_d = word_cnt_q + 16'd1;
                bit_cnt_d  = {BCW{1'b0}};
                if ((FRAME_WORDS != 0) && ((word_cnt_q + 16'd1) == FW16)) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_HUNT;
                    zero_cnt_d   = 4'd0;
                end else begin
                    state_d = ST_DATA;
                end
            end else begin
                word_cnt_d = word_cnt_d;
            end
        end else begin
            state_d = state_q;
        end

        sync_locked_d = (state_d == ST_DATA) || (state_d == ST_PAR);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_HUNT;
            zero_cnt_q    <= 4'd0;
            sfd_idx_q     <= 5'd0;
            bit_cnt_q     <= {BCW{1'b0}};
            word_cnt_q    <= 16'd0;
            shreg_q       <= {WORD_BITS{1'b0}};
            out_data_q    <= {WORD_BITS{1'b0}};
            out_perr_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            sync_locked_q <= 1'b0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            zero_cnt_q    <= zero_cnt_d;
            sfd_idx_q     <= sfd_idx_d;
            bit_cnt_q     <= bit_cnt_d;
            word_cnt_q    <= word_cnt_d;
            shreg_q       <= shreg_d;
            out_data_q    <= out_data_d;
            out_perr_q    <= out_perr_d;
            out_valid_q   <= out_valid_d;
            sync_locked_q <= sync_locked_d;
            frame_done_q  <= frame_done_d;
            overflow_q    <= overflow_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_perr    = out_perr_q;
    assign out_valid   = out_valid_q;
    assign sync_locked = sync_locked_q;
    assign frame_done  = frame_done_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_vppm_word_deframer.sv
// Directed bench for vppm_word_deframer: a streaming instance and a 2-word-frame instance share stimulus.
module tb_vppm_word_deframer;

    logic        clk;
    logic        reset_n;
    logic        freq_lock;
    logic        bit_in;
    logic        bit_stb;
    logic        out_ready;
    logic [11:0] d0_data, d1_data;
    logic        d0_perr, d1_perr, d0_valid, d1_valid, d0_sync, d1_sync;
    logic        d0_fd, d1_fd, d0_ovf, d1_ovf;

    int n_vec;
    int n_err;

    vppm_word_deframer dut0 (
        .clk(clk), .reset_n(reset_n), .freq_lock(freq_lock), .bit_in(bit_in), .bit_stb(bit_stb),
        .out_data(d0_data), .out_perr(d0_perr), .out_valid(d0_valid), .out_ready(out_ready),
        .sync_locked(d0_sync), .frame_done(d0_fd), .overflow(d0_ovf)
    );

    vppm_word_deframer #(.FRAME_WORDS(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .freq_lock(freq_lock), .bit_in(bit_in), .bit_stb(bit_stb),
        .out_data(d1_data), .out_perr(d1_perr), .out_valid(d1_valid), .out_ready(out_ready),
        .sync_locked(d1_sync), .frame_done(d1_fd), .overflow(d1_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] word;
        logic        rdy_body;
        logic        rdy_last;
        logic [11:0] exp_data;
        logic        exp_valid;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered and left on a negedge; the posedge in between samples the bit.
    task automatic send_bit(input logic b);
        bit_in  = b;
        bit_stb = 1'b1;
        @(negedge clk);
        bit_stb = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_word(input logic [11:0] w, input logic rb, input logic rl, input logic flip);
        logic [12:0] bits;
        int          nb;
`ifdef VPPM_DEFRAMER_PARITY_EN
        bits = {w, (^w) ^ flip};
        nb   = 13;
`else
        bits = {flip, w};
        nb   = 12;
`endif
        for (int i = nb - 1; i >= 0; i--) begin
            out_ready = (i == 0) ? rl : rb;
            send_bit(bits[i]);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset_n = 1'b0; freq_lock = 1'b0; bit_in = 1'b0; bit_stb = 1'b0; out_ready = 1'b0;
        //                word    rb    rl    exp_data valid  ovf
        vecs[0] = '{12'hABC, 1'b0, 1'b0, 12'hABC, 1'b1, 1'b0};
        vecs[1] = '{12'h123, 1'b0, 1'b0, 12'hABC, 1'b1, 1'b1};
        vecs[2] = '{12'h456, 1'b0, 1'b1, 12'h456, 1'b1, 1'b1};
        vecs[3] = '{12'h789, 1'b1, 1'b1, 12'h789, 1'b1, 1'b1};
        vecs[4] = '{12'h000, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1};
        vecs[5] = '{12'hFFF, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1};
        vecs[6] = '{12'h5A5, 1'b1, 1'b1, 12'h5A5, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_data", 32'(d0_data), 32'h0);
        check("rst_valid", 32'(d0_valid), 32'h0);
        check("rst_perr", 32'(d0_perr), 32'h0);
        check("rst_sync", 32'(d0_sync), 32'h0);
        check("rst_fd", 32'(d0_fd), 32'h0);
        check("rst_ovf", 32'(d0_ovf), 32'h0);
        reset_n = 1'b1;
        freq_lock = 1'b1;

        // Short preamble, then a bad SFD: never locks.
        send_bits(32'h0, 4);
        send_bits(32'hA, 4);
        send_word(12'hABC, 1'b0, 1'b0, 1'b0);
        check("short_pre_sync", 32'(d0_sync), 32'h0);
        check("short_pre_valid", 32'(d0_valid), 32'h0);
        send_bits(32'h0, 5);
        send_bits(32'hB, 4);
        check("bad_sfd_sync", 32'(d0_sync), 32'h0);
        check("bad_sfd_sync1", 32'(d1_sync), 32'h0);
        check("bad_sfd_valid", 32'(d0_valid), 32'h0);

        // Lock, deliver one word, then reset mid-word.
        send_bits(32'h0, 5);
        send_bits(32'hA, 4);
        check("lock_sync", 32'(d0_sync), 32'h1);
        send_word(12'hABC, 1'b0, 1'b0, 1'b0);
        check("pre_rst_data", 32'(d0_data), 32'hABC);
        check("pre_rst_valid", 32'(d0_valid), 32'h1);
        send_bits(32'h2A, 6);
        reset_n = 1'b0;
        #1;
        check("async_rst_data", 32'(d0_data), 32'h0);
        check("async_rst_valid", 32'(d0_valid), 32'h0);
        check("async_rst_sync", 32'(d0_sync), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        send_bits(32'h0, 7);
        send_bits(32'hA, 4);
        send_word(12'hABC, 1'b0, 1'b0, 1'b0);
        check("relock_data", 32'(d0_data), 32'hABC);
        check("relock_valid", 32'(d0_valid), 32'h1);
        check("relock_ovf", 32'(d0_ovf), 32'h0);
        check("relock_fd1", 32'(d1_fd), 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("accept_valid", 32'(d0_valid), 32'h0);

        // Back-pressure table on the streaming instance.
        for (int i = 0; i < 7; i++) begin
            send_word(vecs[i].word, vecs[i].rdy_body, vecs[i].rdy_last, 1'b0);
            check($sformatf("vec%0d_data", i), 32'(d0_data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_valid", i), 32'(d0_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_ovf", i), 32'(d0_ovf), 32'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_sync", i), 32'(d0_sync), 32'h1);
            check($sformatf("vec%0d_perr", i), 32'(d0_perr), 32'h0);
        end

        // Loss of frequency lock mid-word.
        send_bits(32'h16, 5);
        freq_lock = 1'b0;
        @(negedge clk);
        check("unlock_sync", 32'(d0_sync), 32'h0);
        check("unlock_valid", 32'(d0_valid), 32'h1);
        check("unlock_data", 32'(d0_data), 32'h5A5);
        freq_lock = 1'b1;
        send_bits(32'h7F, 7);
        send_bits(32'h0F0, 12);
        check("no_relock_sync", 32'(d0_sync), 32'h0);
        check("no_relock_data", 32'(d0_data), 32'h5A5);
        send_bits(32'h0, 5);
        send_bits(32'hA, 4);
        send_word(12'h321, 1'b1, 1'b1, 1'b0);
        check("full_relock_data", 32'(d0_data), 32'h321);
        check("full_relock_valid", 32'(d0_valid), 32'h1);
        check("ovf_sticky", 32'(d0_ovf), 32'h1);

        // Two-word frame on the second instance.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("rst2_ovf", 32'(d0_ovf), 32'h0);
        send_bits(32'h0, 5);
        send_bits(32'hA, 4);
        send_word(12'hABC, 1'b1, 1'b1, 1'b0);
        check("frm_w0_data", 32'(d1_data), 32'hABC);
        check("frm_w0_fd", 32'(d1_fd), 32'h0);
        check("frm_w0_sync", 32'(d1_sync), 32'h1);
        send_word(12'h123, 1'b1, 1'b1, 1'b0);
        check("frm_w1_data", 32'(d1_data), 32'h123);
        check("frm_w1_valid", 32'(d1_valid), 32'h1);
        check("frm_w1_fd", 32'(d1_fd), 32'h1);
        check("frm_w1_sync", 32'(d1_sync), 32'h0);
        check("stream_sync", 32'(d0_sync), 32'h1);
        check("stream_fd", 32'(d0_fd), 32'h0);
        @(negedge clk);
        check("frm_fd_pulse", 32'(d1_fd), 32'h0);
        check("frm_ovf", 32'(d1_ovf), 32'h0);

`ifdef VPPM_DEFRAMER_PARITY_EN
        send_word(12'hABC, 1'b1, 1'b1, 1'b0);
        check("par_ok_data", 32'(d0_data), 32'hABC);
        check("par_ok_perr", 32'(d0_perr), 32'h0);
        send_word(12'hABC, 1'b1, 1'b1, 1'b1);
        check("par_bad_perr", 32'(d0_perr), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
